// File: rtl/fixed_point_pkg.sv
// Shared signed fixed-point definitions (Q1.17 in 19 bits) and the round/saturate helper
// used by the matrix multiplier, sequence multiplier and gate table.
package fixed_point_pkg;
  localparam int NUMERIC_BITS = 19;
  localparam int FRAC_BITS    = 17;
  localparam int PROD_BITS    = 2*NUMERIC_BITS + 1;
  localparam int ACC_BITS     = 2*NUMERIC_BITS + 2;

  typedef logic signed [NUMERIC_BITS-1:0] fp_t;
  typedef logic signed [PROD_BITS-1:0]    prod_t;
  typedef logic signed [ACC_BITS-1:0]     acc_t;

  localparam fp_t FP_ONE = fp_t'(1 << FRAC_BITS);
  localparam fp_t FP_MAX = {1'b0, {(NUMERIC_BITS-1){1'b1}}};
  localparam fp_t FP_MIN = {1'b1, {(NUMERIC_BITS-1){1'b0}}};

  // Round half toward +inf, then clamp into the fp_t range.
  function automatic fp_t round_sat(input acc_t acc);
    acc_t r;
    r = (acc + (acc_t'(1) <<< (FRAC_BITS-1))) >>> FRAC_BITS;
    if (r > acc_t'(FP_MAX))      return FP_MAX;
    else if (r < acc_t'(FP_MIN)) return FP_MIN;
    else                         return fp_t'(r);
  endfunction
endpackage

// File: rtl/complex_product.sv
// Combinational full-precision complex multiply: four signed multipliers plus add/sub.
module complex_product
  import fixed_point_pkg::*;
(
  input  fp_t   ar_i,
  input  fp_t   ai_i,
  input  fp_t   br_i,
  input  fp_t   bi_i,
  output prod_t re_o,
  output prod_t im_o
);
  typedef logic signed [2*NUMERIC_BITS-1:0] mul_t;

  mul_t m_rr, m_ii, m_ri, m_ir;

  assign m_rr = mul_t'(ar_i) * mul_t'(br_i);
  assign m_ii = mul_t'(ai_i) * mul_t'(bi_i);
  assign m_ri = mul_t'(ar_i) * mul_t'(bi_i);
  assign m_ir = mul_t'(ai_i) * mul_t'(br_i);

  assign re_o = prod_t'(m_rr) - prod_t'(m_ii);
  assign im_o = prod_t'(m_ri) + prod_t'(m_ir);
endmodule

// File: rtl/complex_matrix_multiplier.sv
// 2x2 complex matrix multiply A*B, one shared complex multiplier over 8 cycles,
// followed by a single round/saturate cycle and a one-cycle done pulse.
module complex_matrix_multiplier
  import fixed_point_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  fp_t  multiplier_a      [0:1][0:1][0:1],
  input  fp_t  multiplier_b      [0:1][0:1][0:1],
  input  logic multiplier_ready,
  output logic multiplier_done,
  output fp_t  multiplier_result [0:1][0:1][0:1]
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       done_q;
  fp_t        a_q      [0:1][0:1][0:1];
  fp_t        b_q      [0:1][0:1][0:1];
  acc_t       acc_q    [0:1][0:1][0:1];
  fp_t        result_q [0:1][0:1][0:1];

  logic  ii, jj, kk;
  prod_t p_re, p_im;

  assign {ii, jj, kk} = idx_q;

  complex_product u_cprod (
    .ar_i (a_q[ii][kk][0]),
    .ai_i (a_q[ii][kk][1]),
    .br_i (b_q[kk][jj][0]),
    .bi_i (b_q[kk][jj][1]),
    .re_o (p_re),
    .im_o (p_im)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (multiplier_ready) begin
        state_d = S_MAC;
        idx_d   = 3'd0;
      end
      S_MAC: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = S_ROUND;
      end
      S_ROUND: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture needs no reset: the registers are only read after a capture.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && multiplier_ready) begin
      a_q <= multiplier_a;
      b_q <= multiplier_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          for (int c = 0; c < 2; c++) begin
            acc_q[i][j][c]    <= '0;
            result_q[i][j][c] <= '0;
          end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= (state_q == S_ROUND);
      if (state_q == S_MAC) begin
        // k=0 starts a fresh dot product, k=1 accumulates the second term.
        if (!kk) begin
          acc_q[ii][jj][0] <= acc_t'(p_re);
          acc_q[ii][jj][1] <= acc_t'(p_im);
        end else begin
          acc_q[ii][jj][0] <= acc_q[ii][jj][0] + acc_t'(p_re);
          acc_q[ii][jj][1] <= acc_q[ii][jj][1] + acc_t'(p_im);
        end
      end
      if (state_q == S_ROUND) begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++)
            for (int c = 0; c < 2; c++)
              result_q[i][j][c] <= round_sat(acc_q[i][j][c]);
      end
    end
  end

  assign multiplier_done   = done_q;
  assign multiplier_result = result_q;
endmodule

// File: tb/tb_complex_matrix_multiplier.sv
// Directed bench for complex_matrix_multiplier with a result scoreboard and a behavioural model.
module tb_complex_matrix_multiplier;
  import fixed_point_pkg::*;

  localparam int RW = 8*NUMERIC_BITS;

  logic clk = 1'b0;
  logic reset;
  logic ready;
  logic done;
  fp_t  ta  [0:1][0:1][0:1];
  fp_t  tb  [0:1][0:1][0:1];
  fp_t  res [0:1][0:1][0:1];

  int tests = 0;
  int fails = 0;
  logic [RW-1:0] sb [$];

  always #5 clk = ~clk;

  complex_matrix_multiplier dut (
    .clk               (clk),
    .reset             (reset),
    .multiplier_a      (ta),
    .multiplier_b      (tb),
    .multiplier_ready  (ready),
    .multiplier_done   (done),
    .multiplier_result (res)
  );

  function automatic logic [RW-1:0] flat_res();
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int c = 0; c < 2; c++)
          r[((i*2+j)*2+c)*NUMERIC_BITS +: NUMERIC_BITS] = res[i][j][c];
    return r;
  endfunction

  function automatic logic [RW-1:0] model();
    logic [RW-1:0] r;
    longint acc_re, acc_im, ar, ai, br, bi, v;
    r = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc_re = 0;
        acc_im = 0;
        for (int k = 0; k < 2; k++) begin
          ar = longint'(ta[i][k][0]); ai = longint'(ta[i][k][1]);
          br = longint'(tb[k][j][0]); bi = longint'(tb[k][j][1]);
          acc_re += ar*br - ai*bi;
          acc_im += ar*bi + ai*br;
        end
        for (int c = 0; c < 2; c++) begin
          v = ((c == 0 ? acc_re : acc_im) + 65536) >>> 17;
          if (v > 262143)  v = 262143;
          if (v < -262144) v = -262144;
          r[((i*2+j)*2+c)*NUMERIC_BITS +: NUMERIC_BITS] = v[NUMERIC_BITS-1:0];
        end
      end
    return r;
  endfunction

  task automatic clr_ops();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int c = 0; c < 2; c++) begin
          ta[i][j][c] = '0;
          tb[i][j][c] = '0;
        end
  endtask

  // Strobe with the current operands, then scramble them after the capture edge.
  task automatic drive_start();
    ready = 1'b1;
    sb.push_back(model());
    @(posedge clk); #1;
    ready = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int c = 0; c < 2; c++) begin
          ta[i][j][c] = fp_t'($urandom);
          tb[i][j][c] = fp_t'($urandom);
        end
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    int cnt;
    logic [RW-1:0] exp_v, got_v;
    cnt = 0;
    while (done !== 1'b1 && cnt < 30) begin
      @(posedge clk); #1;
      cnt++;
    end
    tests++;
    assert (cnt === exp_lat) else begin
      fails++;
      $error("FAIL %s latency: got %0d cycles, expected %0d", tag, cnt, exp_lat);
    end
    exp_v = sb.pop_front();
    got_v = flat_res();
    tests++;
    assert (got_v === exp_v) else begin
      fails++;
      $error("FAIL %s result: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk); #1;
    tests++;
    assert (done === 1'b0) else begin
      fails++;
      $error("FAIL %s done width: got %b expected 0", tag, done);
    end
  endtask

  task automatic run_op(input string tag);
    drive_start();
    wait_done(9, tag);
    check_pulse_end(tag);
  endtask

  task automatic watch_no_done(input int n, input string tag);
    int seen;
    seen = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    tests++;
    assert (seen === 0) else begin
      fails++;
      $error("FAIL %s spurious done: got %0d pulses expected 0", tag, seen);
    end
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    clr_ops();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tests++;
    assert (done === 1'b0) else begin
      fails++; $error("FAIL reset done: got %b expected 0", done);
    end
    tests++;
    assert (flat_res() === '0) else begin
      fails++; $error("FAIL reset result: got %h expected 0", flat_res());
    end

    // Identity x identity
    clr_ops();
    ta[0][0][0] = FP_ONE; ta[1][1][0] = FP_ONE;
    tb[0][0][0] = FP_ONE; tb[1][1][0] = FP_ONE;
    run_op("identity");
    tests++;
    assert (res[0][0][0] === FP_ONE && res[0][1][0] === '0) else begin
      fails++; $error("FAIL identity entry: got %h/%h expected %h/0", res[0][0][0], res[0][1][0], FP_ONE);
    end

    // Hadamard x Hadamard
    clr_ops();
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ta[i][j][0] = (i == 1 && j == 1) ? fp_t'(-92682) : fp_t'(92682);
        tb[i][j][0] = (i == 1 && j == 1) ? fp_t'(-92682) : fp_t'(92682);
      end
    run_op("hadamard");
    tests++;
    assert (res[1][1][0] === FP_ONE && res[1][0][0] === '0) else begin
      fails++; $error("FAIL hadamard entry: got %h/%h expected %h/0", res[1][1][0], res[1][0][0], FP_ONE);
    end

    // diag(j) x diag(j) = -I
    clr_ops();
    ta[0][0][1] = FP_ONE; ta[1][1][1] = FP_ONE;
    tb[0][0][1] = FP_ONE; tb[1][1][1] = FP_ONE;
    run_op("diag_j");
    tests++;
    assert (res[0][0][0] === fp_t'(-131072) && res[0][0][1] === '0) else begin
      fails++; $error("FAIL diag_j entry: got %h/%h expected %h/0", res[0][0][0], res[0][0][1], fp_t'(-131072));
    end

    // Rounding half toward +inf
    clr_ops();
    ta[0][0][0] = fp_t'(1); tb[0][0][0] = fp_t'(65536);
    run_op("round_pos");
    tests++;
    assert (res[0][0][0] === fp_t'(1)) else begin
      fails++; $error("FAIL round_pos entry: got %0d expected 1", res[0][0][0]);
    end
    clr_ops();
    ta[0][0][0] = fp_t'(-1); tb[0][0][0] = fp_t'(65536);
    run_op("round_neg");
    tests++;
    assert (res[0][0][0] === fp_t'(0)) else begin
      fails++; $error("FAIL round_neg entry: got %0d expected 0", res[0][0][0]);
    end

    // Saturation at both rails
    clr_ops();
    ta[0][0][0] = FP_MAX; tb[0][0][0] = FP_MAX;
    run_op("sat_pos");
    tests++;
    assert (res[0][0][0] === fp_t'(262143)) else begin
      fails++; $error("FAIL sat_pos entry: got %0d expected 262143", res[0][0][0]);
    end
    clr_ops();
    ta[0][0][0] = FP_MIN; tb[0][0][0] = FP_MAX;
    run_op("sat_neg");
    tests++;
    assert (res[0][0][0] === fp_t'(-262144)) else begin
      fails++; $error("FAIL sat_neg entry: got %0d expected -262144", res[0][0][0]);
    end

    // Strobe during MAC is ignored and not queued
    clr_ops();
    ta[0][1][0] = fp_t'(3000); ta[1][0][1] = fp_t'(-7000);
    tb[1][0][0] = fp_t'(50000); tb[0][1][1] = fp_t'(20000);
    drive_start();
    repeat (3) @(posedge clk);
    #1;
    clr_ops();
    ta[0][0][0] = FP_ONE; tb[0][0][0] = FP_ONE;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    wait_done(5, "mac_strobe");
    watch_no_done(12, "mac_strobe");

    // Back-to-back: strobe in the done cycle
    clr_ops();
    ta[0][0][0] = fp_t'(40000); ta[1][1][1] = fp_t'(-90000);
    tb[0][0][0] = fp_t'(100000); tb[1][1][0] = fp_t'(70000);
    drive_start();
    wait_done(9, "b2b_first");
    clr_ops();
    ta[1][0][0] = fp_t'(-120000); ta[1][1][1] = fp_t'(33333);
    tb[0][1][1] = fp_t'(77777); tb[1][1][0] = fp_t'(-5);
    drive_start();
    tests++;
    assert (done === 1'b0) else begin
      fails++; $error("FAIL b2b done width: got %b expected 0", done);
    end
    wait_done(9, "b2b_second");
    check_pulse_end("b2b_second");

    // Reset sampled at edge 4 aborts with no done
    clr_ops();
    ta[0][0][0] = FP_ONE; tb[0][0][0] = FP_ONE;
    drive_start();
    void'(sb.pop_front());
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    assert (done === 1'b0 && flat_res() === '0) else begin
      fails++; $error("FAIL abort reset: got done=%b result=%h expected 0/0", done, flat_res());
    end
    watch_no_done(15, "abort");
    tests++;
    assert (flat_res() === '0) else begin
      fails++; $error("FAIL abort result: got %h expected 0", flat_res());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
